// File: rtl/fp_intcast_accum.sv
// fp_intcast_accum: saturating reduction of INT32 cast results with NV count and sticky NX/sat flags.
module fp_intcast_accum #(
    parameter int SUM_W = 48,
    parameter int LEN_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      in_data_i,
    input  logic [4:0]       in_status_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [SUM_W-1:0] out_sum_o,
    output logic [LEN_W-1:0] out_nv_cnt_o,
    output logic             out_nx_o,
    output logic             out_sat_o,
    output logic             busy_o
);
    typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;
    state_t state_q, state_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d, nv_q, nv_d;
    logic nx_q, nx_d, sat_q, sat_d, beat, ovf;
    logic [SUM_W:0] wide;
    logic unused_status;
    assign unused_status = ^in_status_i[3:1];
    assign beat = state_q == ACCUM && in_valid_i;
    assign wide = {sum_q[SUM_W-1], sum_q} + {{(SUM_W-31){in_data_i[31]}}, in_data_i};
    // the two top bits of the widened sum disagree exactly when the result left the SUM_W range
    assign ovf = wide[SUM_W] ^ wide[SUM_W-1];
    always_comb begin
        state_d = state_q;
        sum_d = sum_q;
        len_d = len_q;
        cnt_d = cnt_q;
        nv_d = nv_q;
        nx_d = nx_q;
        sat_d = sat_q;
        if (state_q == IDLE && start_i) begin
            state_d = len_i == '0 ? EMIT : ACCUM;
            len_d = len_i;
            sum_d = '0;
            cnt_d = '0;
            nv_d = '0;
            nx_d = 1'b0;
            sat_d = 1'b0;
        end
        if (beat) begin
            sum_d = ovf ? {wide[SUM_W], {(SUM_W-1){~wide[SUM_W]}}} : wide[SUM_W-1:0];
            sat_d = sat_q | ovf;
            cnt_d = cnt_q + LEN_W'(1);
            nv_d = nv_q + LEN_W'(in_status_i[4]);
            nx_d = nx_q | in_status_i[0];
            state_d = cnt_d == len_q ? EMIT : ACCUM;
        end
        if (state_q == EMIT && out_ready_i) state_d = IDLE;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sum_q <= '0;
            len_q <= '0;
            cnt_q <= '0;
            nv_q <= '0;
            nx_q <= 1'b0;
            sat_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q <= sum_d;
            len_q <= len_d;
            cnt_q <= cnt_d;
            nv_q <= nv_d;
            nx_q <= nx_d;
            sat_q <= sat_d;
        end
    end
    assign in_ready_o = state_q == ACCUM;
    assign out_valid_o = state_q == EMIT;
    assign busy_o = state_q != IDLE;
    assign out_sum_o = sum_q;
    assign out_nv_cnt_o = nv_q;
    assign out_nx_o = nx_q;
    assign out_sat_o = sat_q;
endmodule

// File: tb/tb_fp_intcast_accum.sv
// tb_fp_intcast_accum: table-driven jobs plus hand-written corner sequences, scoreboard-checked records.
module tb_fp_intcast_accum;
    localparam int SUM_W = 33;
    localparam int LEN_W = 16;
    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             start_i = 1'b0;
    logic [LEN_W-1:0] len_i = '0;
    logic             in_valid_i = 1'b0;
    logic             in_ready_o;
    logic [31:0]      in_data_i = '0;
    logic [4:0]       in_status_i = '0;
    logic             out_valid_o;
    logic             out_ready_i = 1'b1;
    logic [SUM_W-1:0] out_sum_o;
    logic [LEN_W-1:0] out_nv_cnt_o;
    logic             out_nx_o;
    logic             out_sat_o;
    logic             busy_o;

    fp_intcast_accum #(.SUM_W(SUM_W), .LEN_W(LEN_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .len_i(len_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .in_status_i(in_status_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_sum_o(out_sum_o), .out_nv_cnt_o(out_nv_cnt_o), .out_nx_o(out_nx_o),
        .out_sat_o(out_sat_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        longint sum;
        int     nv;
        bit     nx;
        bit     sat;
    } rec_t;

    typedef struct {
        int               len;
        logic [3:0][31:0] d;
        logic [3:0][4:0]  st;
        rec_t             r;
    } job_t;

    rec_t sb[$];
    rec_t e;
    job_t tab[9];
    int checks = 0;
    int errors = 0;
    int rdy_cyc = 0;
    int val_cyc = 0;
    int hs_cnt = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    function automatic job_t mk(input int len, input logic [31:0] a, b, c, f,
                                input logic [4:0] sa, sbb, sc, sf,
                                input longint sum, input int nv, input bit nx, input bit sat);
        job_t j;
        j.len = len;
        j.d = {f, c, b, a};
        j.st = {sf, sc, sbb, sa};
        j.r = '{sum, nv, nx, sat};
        return j;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 20 && busy_o; k++) tick();
        chk("idle_bound", longint'(busy_o), 0);
    endtask

    always @(negedge clk_i) begin
        if (in_ready_o) rdy_cyc++;
        if (out_valid_o) val_cyc++;
        if (out_valid_o && out_ready_i) begin
            hs_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_record sum=%0d", longint'($signed(out_sum_o)));
            end else begin
                e = sb.pop_front();
                chk("rec_sum", longint'($signed(out_sum_o)), e.sum);
                chk("rec_nv", longint'(out_nv_cnt_o), longint'(e.nv));
                chk("rec_nx", longint'(out_nx_o), longint'(e.nx));
                chk("rec_sat", longint'(out_sat_o), longint'(e.sat));
            end
        end
    end

    task automatic run_job(input job_t j);
        rdy_cyc = 0;
        val_cyc = 0;
        sb.push_back(j.r);
        start_i = 1'b1;
        len_i = j.len[LEN_W-1:0];
        tick();
        start_i = 1'b0;
        for (int b = 0; b < j.len; b++) begin
            in_valid_i = 1'b1;
            in_data_i = j.d[b];
            in_status_i = j.st[b];
            tick();
        end
        in_valid_i = 1'b0;
        @(negedge clk_i);
        chk("latency_valid", longint'(out_valid_o), 1);
        tick();
        @(negedge clk_i);
        chk("busy_drop", longint'(busy_o), 0);
        chk("in_ready_cycles", longint'(rdy_cyc), longint'(j.len));
        chk("out_valid_cycles", longint'(val_cyc), 1);
        wait_idle();
    endtask

    initial begin
        int hs0;
        logic [5:0] vpat;
        logic [2:0][31:0] bpd;
        int bi;
        tab[0] = mk(4, 32'd1, 32'd2, 32'd3, 32'hFFFFFFF6, 0, 0, 0, 0, -4, 0, 0, 0);
        tab[1] = mk(3, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0, 0, 0, 0, 64'sd4294967295, 0, 0, 1);
        tab[2] = mk(3, 32'h80000000, 32'h80000000, 32'h80000000, 0, 0, 0, 0, 0, -64'sd4294967296, 0, 0, 1);
        tab[3] = mk(2, 32'h7FFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 64'sd2147483646, 0, 0, 0);
        tab[4] = mk(3, 0, 0, 0, 0, 5'h10, 5'h01, 5'h11, 0, 0, 2, 1, 0);
        tab[5] = mk(3, 32'd4, 32'd5, 32'd6, 0, 5'h0E, 5'h0E, 5'h0E, 0, 15, 0, 0, 0);
        tab[6] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tab[7] = mk(1, 32'd9, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0);
        tab[8] = mk(4, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000, 0, 0, 0, 5'h01,
                    64'sd2147483647, 0, 1, 1);

        tick();
        tick();
        @(negedge clk_i);
        chk("rst_busy", longint'(busy_o), 0);
        chk("rst_in_ready", longint'(in_ready_o), 0);
        chk("rst_out_valid", longint'(out_valid_o), 0);
        chk("rst_sum", longint'(out_sum_o), 0);
        rst_ni = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_job(tab[i]);
            tick();
        end

        // backpressure: gapped input, stalled output
        rdy_cyc = 0;
        val_cyc = 0;
        hs0 = hs_cnt;
        out_ready_i = 1'b0;
        vpat = 6'b101001;
        bpd = {32'd7, 32'd6, 32'd5};
        bi = 0;
        sb.push_back('{18, 0, 1'b0, 1'b0});
        start_i = 1'b1;
        len_i = 16'd3;
        tick();
        start_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid_i = vpat[c];
            in_data_i = vpat[c] ? bpd[bi] : 32'hDEAD;
            in_status_i = 5'h0;
            if (vpat[c]) bi++;
            tick();
        end
        in_valid_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            chk("stall_valid", longint'(out_valid_o), 1);
            chk("stall_sum", longint'($signed(out_sum_o)), 18);
            tick();
        end
        out_ready_i = 1'b1;
        tick();
        @(negedge clk_i);
        chk("bp_busy_drop", longint'(busy_o), 0);
        chk("bp_handshakes", longint'(hs_cnt - hs0), 1);
        chk("bp_valid_cycles", longint'(val_cyc), 6);
        chk("bp_ready_cycles", longint'(rdy_cyc), 6);
        wait_idle();
        tick();

        // start pulsed during ACCUM must not change the job length
        rdy_cyc = 0;
        sb.push_back('{7, 0, 1'b0, 1'b0});
        start_i = 1'b1;
        len_i = 16'd2;
        tick();
        in_valid_i = 1'b1;
        in_data_i = 32'd3;
        len_i = 16'd5;
        tick();
        start_i = 1'b0;
        in_data_i = 32'd4;
        tick();
        in_valid_i = 1'b0;
        @(negedge clk_i);
        chk("ign_start_valid", longint'(out_valid_o), 1);
        tick();
        @(negedge clk_i);
        chk("ign_start_busy", longint'(busy_o), 0);
        chk("ign_start_ready_cycles", longint'(rdy_cyc), 2);
        wait_idle();
        tick();

        // reset mid-job abandons the job
        start_i = 1'b1;
        len_i = 16'd5;
        tick();
        start_i = 1'b0;
        in_valid_i = 1'b1;
        in_status_i = 5'h11;
        in_data_i = 32'd1;
        tick();
        in_data_i = 32'd2;
        tick();
        in_valid_i = 1'b0;
        in_status_i = 5'h0;
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("mid_rst_busy", longint'(busy_o), 0);
        chk("mid_rst_in_ready", longint'(in_ready_o), 0);
        chk("mid_rst_out_valid", longint'(out_valid_o), 0);
        chk("mid_rst_sum", longint'(out_sum_o), 0);
        chk("mid_rst_nv", longint'(out_nv_cnt_o), 0);
        chk("mid_rst_nx", longint'(out_nx_o), 0);
        chk("mid_rst_sat", longint'(out_sat_o), 0);
        tick();

        run_job(tab[7]);
        tick();
        run_job(tab[8]);
        tick();
        chk("sb_empty", longint'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
